// File: rtl/arb_pkg.sv
// arb_pkg
// Shared definitions for the memory port arbiter: FSM state encoding,
// grant-owner codes and the default timing parameters.
// No ports (package).
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_XFER = 2'd1,
    DM_XFER = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Owner of the access currently in flight.
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

  // Wide enough for MEM_LAT and STARVE_MAX up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// arb_lat_counter
// Loadable up-counter that paces one fixed-latency memory access.
// tc is high while the count equals MEM_LAT.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   clear      in   synchronous clear to zero (highest priority)
//   load       in   synchronous load of load_value
//   load_value in   value to load
//   enable     in   increment by one
//   tc         out  terminal count (count == MEM_LAT)
module arb_lat_counter
  import arb_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(MEM_LAT));

endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
// Shares one single-port memory between the instruction-fetch port and
// the data-memory port. One access at a time: grant in IDLE, MEM_LAT+1
// transfer cycles, then a one-cycle DONE that carries the ack.
// Data port has strict priority unless ARB_STARVE_GUARD_EN is defined,
// in which case IF is forced in after STARVE_MAX DM grants that were
// made while IF was waiting.
// Ports:
//   clock, reset                 clock and async active-low reset
//   if_req/if_addr               fetch request (held until if_ack)
//   if_ack/if_rdata              fetch completion pulse and data
//   dm_req/dm_we/dm_addr/dm_wdata data request (held until dm_ack)
//   dm_ack/dm_rdata              data completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (registered)
//   mem_rdata                    memory read data, MEM_LAT after mem_en
//   if_stall/dm_stall            request pending and not yet acked
module memory_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              dm_stall
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("memory_port_arbiter: MEM_LAT and STARVE_MAX must be in 1..15");
  end

  arb_state_t state, state_next;
  logic       owner;
  logic       grant_if, grant_dm;
  logic       force_if;
  logic       in_xfer;
  logic       tc;

  assign in_xfer = (state == IF_XFER) || (state == DM_XFER);

  arb_lat_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_lat_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (state == DONE),
    .load       (grant_if | grant_dm),
    .load_value ({CNT_W{1'b0}}),
    .enable     (in_xfer & ~tc),
    .tc         (tc)
  );

`ifdef ARB_STARVE_GUARD_EN
  // Counts DM grants that overtook a waiting fetch; once it reaches
  // STARVE_MAX the next IDLE decision goes to IF regardless of dm_req.
  logic [CNT_W-1:0] streak;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (grant_if) begin
      streak <= '0;
    end else if (grant_dm && if_req) begin
      streak <= streak + 1'b1;
    end
  end

  assign force_if = if_req && (streak == CNT_W'(STARVE_MAX));
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grants are only made from IDLE, so a requester still holding req
  // during its DONE cycle cannot be regranted back-to-back.
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && !force_if) begin
          grant_dm   = 1'b1;
          state_next = DM_XFER;
        end else if (if_req) begin
          grant_if   = 1'b1;
          state_next = IF_XFER;
        end
      end
      IF_XFER, DM_XFER: begin
        if (tc) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory command is captured at grant and held for the whole transfer;
  // mem_en is a single-cycle strobe. mem_wdata follows dm_wdata even on
  // a fetch grant, which is harmless because mem_we is 0 then.
  // Read data is captured at terminal count and the ack follows in DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner     <= GNT_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (grant_dm) begin
        owner     <= GNT_DM;
        mem_en    <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (grant_if) begin
        owner     <= GNT_IF;
        mem_en    <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= dm_wdata;
      end
      if (in_xfer && tc) begin
        if (owner == GNT_IF) begin
          if_rdata <= mem_rdata;
          if_ack   <= 1'b1;
        end else begin
          if (!mem_we) begin
            dm_rdata <= mem_rdata;
          end
          dm_ack <= 1'b1;
        end
      end
    end
  end

  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter
// Directed bench for memory_port_arbiter (MEM_LAT=2) with a scoreboard:
// stimulus pushes expected memory commands and acks into queues, a
// negedge monitor pops and compares them. Two extra instances with
// MEM_LAT=1 and MEM_LAT=15 check ack latency.
// Honours ARB_STARVE_GUARD_EN for the starvation grant pattern.
module tb_memory_port_arbiter;
  import arb_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          cyc;
  } mem_exp_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          cyc;
  } ack_exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'hBAD0_0000;
  logic        if_stall, dm_stall;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  memory_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
  ) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .if_stall(if_stall), .dm_stall(dm_stall)
  );

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic dwe,
                                input logic [31:0] daddr, input logic [31:0] dwdata);
    if_req   = ireq;
    if_addr  = iaddr;
    dm_req   = dreq;
    dm_we    = dwe;
    dm_addr  = daddr;
    dm_wdata = dwdata;
  endtask

  task automatic expect_mem(input logic [31:0] a, input logic we,
                            input logic [31:0] wd, input int c);
    mem_exp_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.cyc = c;
    mem_q.push_back(e);
  endtask

  task automatic expect_ack(input logic port, input logic [31:0] d, input int c);
    ack_exp_t e;
    e.port = port; e.data = d; e.cyc = c;
    ack_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Initial contents of the memory model.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0040: rom = 32'h8C09_0004;
      32'h0000_0044: rom = 32'h00A0_0093;
      32'h0000_0080: rom = 32'hCAFE_F00D;
      32'h0000_0100: rom = 32'h1234_5678;
      32'h0000_0200: rom = 32'h1111_0000;
      32'h0000_0300: rom = 32'h2222_0000;
      default:       rom = 32'hBAD0_0001;
    endcase
  endfunction

  // Memory model: data appears only in the cycle exactly MEM_LAT after
  // the mem_en cycle; garbage otherwise.
  logic [31:0] wr_mem [logic [31:0]];
  logic [31:0] pend;
  int          cd = 0;

  always @(negedge clock) begin
    if (mem_en) begin
      if (mem_we) wr_mem[mem_addr] = mem_wdata;
      pend      = wr_mem.exists(mem_addr) ? wr_mem[mem_addr] : rom(mem_addr);
      cd        = 2;
      mem_rdata = 32'hBAD0_0000;
    end else if (cd > 0) begin
      cd--;
      mem_rdata = (cd == 0) ? pend : 32'hBAD0_0000;
    end else begin
      mem_rdata = 32'hBAD0_0000;
    end
  end

  // Scoreboard monitor.
  always @(negedge clock) begin
    mem_exp_t me;
    ack_exp_t ae;
    if (mem_en) begin
      check_output("mem_unexpected", mem_q.size() != 0, 1'b1);
      if (mem_q.size() != 0) begin
        me = mem_q.pop_front();
        check_output("mem_addr", mem_addr, me.addr);
        check_output("mem_we", mem_we, me.we);
        check_output("mem_wdata", mem_wdata, me.wdata);
        check_output("mem_cycle", cyc, me.cyc);
      end
    end
    if (if_ack || dm_ack) begin
      check_output("ack_onehot", if_ack & dm_ack, 1'b0);
      check_output("ack_unexpected", ack_q.size() != 0, 1'b1);
      if (ack_q.size() != 0) begin
        ae = ack_q.pop_front();
        check_output("ack_port", dm_ack, ae.port == GNT_DM);
        check_output("ack_rdata", (ae.port == GNT_DM) ? dm_rdata : if_rdata, ae.data);
        check_output("ack_cycle", cyc, ae.cyc);
      end
    end
  end

  // Latency sweep instances.
  logic [1:0]       sw_if_req = '0;
  logic [1:0][31:0] sw_if_addr = '0;
  logic [1:0]       sw_if_ack, sw_dm_ack, sw_mem_en, sw_mem_we, sw_if_stall, sw_dm_stall;
  logic [1:0][31:0] sw_if_rdata, sw_dm_rdata, sw_mem_addr, sw_mem_wdata;

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int LAT = (g == 0) ? 1 : 15;
    logic [31:0] rdata_l = 32'hBAD0_0000;
    int          cd_l = 0;

    memory_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(4)
    ) u_sw (
      .clock(clock), .reset(reset),
      .if_req(sw_if_req[g]), .if_addr(sw_if_addr[g]),
      .if_ack(sw_if_ack[g]), .if_rdata(sw_if_rdata[g]),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_ack(sw_dm_ack[g]), .dm_rdata(sw_dm_rdata[g]),
      .mem_en(sw_mem_en[g]), .mem_we(sw_mem_we[g]),
      .mem_addr(sw_mem_addr[g]), .mem_wdata(sw_mem_wdata[g]),
      .mem_rdata(rdata_l), .if_stall(sw_if_stall[g]), .dm_stall(sw_dm_stall[g])
    );

    always @(negedge clock) begin
      if (sw_mem_en[g]) begin
        cd_l    = LAT;
        rdata_l = 32'hBAD0_0000;
      end else if (cd_l > 0) begin
        cd_l--;
        rdata_l = (cd_l == 0) ? {16'h5A5A, sw_mem_addr[g][15:0]} : 32'hBAD0_0000;
      end else begin
        rdata_l = 32'hBAD0_0000;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    int c2;
    logic exp_port;

    // Reset state.
    repeat (3) step();
    check_output("rst_if_ack", if_ack, 1'b0);
    check_output("rst_dm_ack", dm_ack, 1'b0);
    check_output("rst_mem_en", mem_en, 1'b0);
    check_output("rst_mem_cmd", {mem_we, mem_addr, mem_wdata}, 65'h0);
    check_output("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
    reset = 1'b1;
    step();
    step();

    // Single fetch.
    $display("[TB] single fetch");
    c = cyc;
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_mem(32'h40, 1'b0, 32'h0, c + 1);
    expect_ack(GNT_IF, 32'h8C09_0004, c + 4);
    for (int k = 0; k <= 4; k++) begin
      #2;
      check_output("t1_if_stall", if_stall, k < 4);
      if (k == 4) if_req = 1'b0;
      step();
    end

    // Simultaneous requests: DM first, then IF.
    $display("[TB] simultaneous requests");
    c = cyc;
    apply_stimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0);
    expect_mem(32'h100, 1'b0, 32'h0, c + 1);
    expect_ack(GNT_DM, 32'h1234_5678, c + 4);
    expect_mem(32'h44, 1'b0, 32'h0, c + 6);
    expect_ack(GNT_IF, 32'h00A0_0093, c + 9);
    for (int k = 0; k <= 9; k++) begin
      #2;
      check_output("t2_if_stall", if_stall, k < 9);
      check_output("t2_dm_stall", dm_stall, k < 4);
      if (k == 4) dm_req = 1'b0;
      if (k == 9) if_req = 1'b0;
      step();
    end

    // Store; dm_rdata must keep the previous load value.
    $display("[TB] store");
    c = cyc;
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    expect_mem(32'h10, 1'b1, 32'hDEAD_BEEF, c + 1);
    expect_ack(GNT_DM, 32'h1234_5678, c + 4);
    for (int k = 0; k <= 4; k++) begin
      #2;
      check_output("t3_dm_stall", dm_stall, k < 4);
      if (k == 3) check_output("t3_mem_hold", {mem_en, mem_we, mem_addr}, {2'b01, 32'h10});
      if (k == 4) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
    end

    // Load back the stored word.
    c = cyc;
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    expect_mem(32'h10, 1'b0, 32'h0, c + 1);
    expect_ack(GNT_DM, 32'hDEAD_BEEF, c + 4);
    for (int k = 0; k <= 4; k++) begin
      #2;
      check_output("t3b_dm_stall", dm_stall, k < 4);
      if (k == 4) dm_req = 1'b0;
      step();
    end

    // Reset in cycle 2 of a fetch: abort, then regrant the held request.
    $display("[TB] reset mid-transfer");
    c = cyc;
    apply_stimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_mem(32'h80, 1'b0, 32'h0, c + 1);
    step();
    step();
    reset = 1'b0;
    #1;
    check_output("t4_acks", {if_ack, dm_ack}, 2'b00);
    check_output("t4_mem_en", mem_en, 1'b0);
    check_output("t4_mem_cmd", {mem_we, mem_addr, mem_wdata}, 65'h0);
    check_output("t4_rdata", {if_rdata, dm_rdata}, 64'h0);
    step();
    reset = 1'b1;
    c2 = cyc;
    expect_mem(32'h80, 1'b0, 32'h0, c2 + 1);
    expect_ack(GNT_IF, 32'hCAFE_F00D, c2 + 4);
    for (int k = 0; k <= 4; k++) begin
      #2;
      check_output("t4_if_stall", if_stall, k < 4);
      if (k == 4) if_req = 1'b0;
      step();
    end

    // Both requests held for six grants.
    $display("[TB] continuous contention");
    c = cyc;
    apply_stimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0);
    for (int g = 0; g < 6; g++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_port = (g == 4) ? GNT_IF : GNT_DM;
`else
      exp_port = GNT_DM;
`endif
      expect_mem((exp_port == GNT_IF) ? 32'h200 : 32'h300, 1'b0, 32'h0, c + 5 * g + 1);
      expect_ack(exp_port, (exp_port == GNT_IF) ? 32'h1111_0000 : 32'h2222_0000, c + 5 * g + 4);
    end
    for (int k = 0; k <= 29; k++) begin
      #2;
`ifdef ARB_STARVE_GUARD_EN
      check_output("t5_if_stall", if_stall, k != 24);
`else
      check_output("t5_if_stall", if_stall, 1'b1);
`endif
      if (k == 29) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
    end

    // Latency sweep: ack exactly MEM_LAT+2 cycles after the request.
    $display("[TB] latency sweep");
    for (int g = 0; g < 2; g++) begin
      int lat;
      int seen;
      lat  = (g == 0) ? 1 : 15;
      seen = -1;
      sw_if_addr[g] = 32'h500;
      sw_if_req[g]  = 1'b1;
      for (int n = 1; n <= 40 && seen < 0; n++) begin
        step();
        if (sw_if_ack[g]) begin
          seen = n;
          #2;
          check_output("sweep_rdata", sw_if_rdata[g], 32'h5A5A_0500);
          check_output("sweep_quiet", {sw_mem_en[g], sw_mem_we[g], sw_dm_ack[g],
                                       sw_dm_stall[g], sw_if_stall[g]}, 5'b0);
          check_output("sweep_zero", {sw_mem_wdata[g], sw_dm_rdata[g]}, 64'h0);
        end
      end
      sw_if_req[g] = 1'b0;
      check_output("sweep_latency", seen, lat + 2);
      step();
      step();
    end

    // Everything expected must have been observed.
    for (int n = 0; n < 20 && (mem_q.size() != 0 || ack_q.size() != 0); n++) step();
    check_output("mem_q_drained", mem_q.size(), 0);
    check_output("ack_q_drained", ack_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
